// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd core and its host: FSM encodings, default word width
// and the result FIFO entry layout.
package gcd_pkg;

    localparam int WORD = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_PUSH   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        SETTLE = ST_SETTLE,
        WAIT   = ST_WAIT,
        PUSH   = ST_PUSH
    } state_t;

    // A FIFO entry is {err, data}: the error flag sits directly above a word-wide result.
    typedef struct packed {
        logic            err;
        logic [WORD-1:0] data;
    } entry_t;

endpackage

// File: rtl/gcd_res_fifo.sv
// Result FIFO for gcd_host: first-word-fall-through, exact occupancy count, power-of-2 depth.
module gcd_res_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gcd_host.sv
// Initiator for a single gcd core: accepts operand pairs, restarts the core per pair,
// bypasses zero operands, aborts hung computations on timeout and queues results.
module gcd_host
    import gcd_pkg::*;
#(
    parameter int word    = WORD,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [word-1:0] req_x,
    input  logic [word-1:0] req_y,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [word-1:0] res_data,
    output logic            res_err,
    output logic            core_rst,
    output logic [word-1:0] core_x,
    output logic [word-1:0] core_y,
    input  logic [word-1:0] core_data,
    input  logic            core_ready,
    output logic            busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int NW = $clog2(DEPTH) + 1;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;
    logic [word-1:0] result_q;
    logic            err_q;
    logic            accept;
    logic            bypass;
    logic            timed_out;
    logic            fifo_full;
    logic            fifo_empty;
    logic [NW-1:0]   fifo_count;
    logic [word:0]   head;

    assign req_ready = !rst && (state == IDLE) && (fifo_count < NW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign bypass    = (req_x == '0) || (req_y == '0);
    assign timed_out = (state == WAIT) && !core_ready && (wait_cnt == CW'(TIMEOUT - 1));
    assign core_rst  = rst || (state == START);
    assign busy      = (state != IDLE);
    assign res_valid = !fifo_empty;
    assign res_data  = head[word-1:0];
    assign res_err   = head[word];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = bypass ? PUSH : START;
            START:   next_state = SETTLE;
            SETTLE:  next_state = WAIT;
            WAIT:    if (core_ready || timed_out) next_state = PUSH;
            PUSH:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A zero operand makes x|y the answer, so the bypass result is loaded at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_x   <= '0;
            core_y   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                core_x   <= req_x;
                core_y   <= req_y;
                result_q <= req_x | req_y;
                err_q    <= 1'b0;
            end
            if (state == SETTLE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                if (core_ready) begin
                    result_q <= core_data;
                    err_q    <= 1'b0;
                end else if (timed_out) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
                if (wait_cnt != CW'(TIMEOUT - 1)) wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    gcd_res_fifo #(
        .W     (word + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      ((state == PUSH) && !fifo_full),
        .push_data ({err_q, result_q}),
        .pop       (res_ready),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
